// File: rtl/div_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_seq_pkg
// Core-wide definitions for the iterative divider in the EX stage.
//   DIV_WIDTH   : operand / result width of the divider
//   DIV_CNT_W   : width of the iteration counter (log2 of DIV_WIDTH)
//   div_state_e : divider control states (DIV_IDLE, DIV_CALC, DIV_FIX)
// ---------------------------------------------------------------------------
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// The {rem, quo} pair is shifted left by one, and the divisor is trial-subtracted
// from the widened partial remainder. When the subtraction does not borrow,
// the difference becomes the new remainder and a 1 enters the quotient LSB.
// Otherwise the shifted remainder is kept and a 0 enters the quotient LSB.
//
// Ports:
//   rem      in  WIDTH  partial remainder before this step
//   quo      in  WIDTH  partial quotient / remaining dividend bits
//   divisor  in  WIDTH  divisor magnitude
//   rem_next out WIDTH  partial remainder after this step
//   quo_next out WIDTH  partial quotient after this step
// ---------------------------------------------------------------------------
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  // Because rem < divisor always holds, a WIDTH+1 bit difference never
  // overflows, and its MSB is a reliable borrow flag.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
// Iterative restoring divider that produces MIPS HI/LO results.
// HI holds the remainder and LO holds the quotient.
// Signed operands are divided as magnitudes, and the signs are restored in a
// final fix-up cycle. The divider therefore takes one accept edge, WIDTH
// iteration edges and one fix-up edge.
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   i_start       in   1      request a division (only looked at in IDLE)
//   i_flush       in   1      abort the operation in flight, no done pulse
//   i_opr1        in   WIDTH  dividend
//   i_opr2        in   WIDTH  divisor
//   is_unsigned   in   1      1 = DIVU, 0 = DIV
//   o_busy        out  1      operation in flight
//   o_done        out  1      one-cycle pulse, results valid
//   o_hi_result   out  WIDTH  remainder, held until the next accepted start
//   o_lo_result   out  WIDTH  quotient, held until the next accepted start
//   o_div_by_zero out  1      divisor was zero, pulses with o_done
// ---------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_opr1,
  input  logic [WIDTH-1:0] i_opr2,
  input  logic             is_unsigned,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi_result,
  output logic [WIDTH-1:0] o_lo_result,
  output logic             o_div_by_zero
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Two's complement negation when en is set; used for both operand
  // magnitudes and result sign correction.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             en);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return en ? $unsigned(-sv) : v;
  endfunction

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dividend_raw;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] opr1_mag;
  logic [WIDTH-1:0] opr2_mag;
  logic             opr1_neg;
  logic             opr2_neg;

  // The most negative value maps onto itself, and that is also its correct
  // unsigned magnitude. Therefore 0x80000000 / -1 needs no special case.
  assign opr1_neg = !is_unsigned && i_opr1[WIDTH-1];
  assign opr2_neg = !is_unsigned && i_opr2[WIDTH-1];
  assign opr1_mag = cond_neg(i_opr1, opr1_neg);
  assign opr2_mag = cond_neg(i_opr2, opr2_neg);

  div_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_next(rem_nx),
    .quo_next(quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= DIV_IDLE;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      dividend_raw  <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      dz            <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_hi_result   <= '0;
      o_lo_result   <= '0;
    end else begin
      o_done        <= 1'b0;
      o_div_by_zero <= 1'b0;

      case (state)
        // Accept: capture magnitudes and sign bookkeeping
        DIV_IDLE: begin
          if (i_start && !i_flush) begin
            state        <= DIV_CALC;
            cnt          <= '0;
            rem          <= '0;
            quo          <= opr1_mag;
            dvsr         <= opr2_mag;
            dividend_raw <= i_opr1;
            sign_q       <= opr1_neg ^ opr2_neg;
            sign_r       <= opr1_neg;
            dz           <= (i_opr2 == '0);
            o_busy       <= 1'b1;
          end
        end

        // Iterate: one restoring step per cycle
        DIV_CALC: begin
          if (i_flush) begin
            state  <= DIV_IDLE;
            o_busy <= 1'b0;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= DIV_FIX;
            end
          end
        end

        // Fix-up: sign correction, result write, done pulse
        DIV_FIX: begin
          state  <= DIV_IDLE;
          o_busy <= 1'b0;
          if (!i_flush) begin
            o_done        <= 1'b1;
            o_div_by_zero <= dz;
            // A zero divisor bypasses sign correction. LO is all ones and HI
            // echoes the dividend exactly as it was presented.
            if (dz) begin
              o_lo_result <= '1;
              o_hi_result <= dividend_raw;
            end else begin
              o_lo_result <= cond_neg(quo, sign_q);
              o_hi_result <= cond_neg(rem, sign_r);
            end
          end
        end

        default: begin
          state  <= DIV_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  a_done_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
                                     o_done |-> !o_busy);
  a_dz_with_done  : assert property (@(posedge clk) disable iff (!rst_n)
                                     o_div_by_zero |-> o_done);

endmodule
